// File: rtl/coproc_pkg.sv
// Shared types for the result transmit path: the result entry record,
// the framer state encoding and the default frame marker bytes.
package coproc_pkg;

    typedef struct packed {
        logic [7:0]  index;
        logic [15:0] data;
        logic        last;
    } result_entry_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SOF,
        ST_IDX,
        ST_DHI,
        ST_DLO,
        ST_EOF,
        ST_CNT,
        ST_CHK,
        ST_GUARD
    } frame_state_t;

    localparam logic [7:0] DEFAULT_SOF_BYTE = 8'hA5;
    localparam logic [7:0] DEFAULT_EOF_BYTE = 8'h5A;

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO for result entries; power-of-two depth, show-ahead read
// (dout_o is the head entry whenever empty_o is low).
module result_fifo
    import coproc_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = result_entry_t
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push_i,
    input  entry_t din_i,
    input  logic   pop_i,
    output entry_t dout_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int AW = $clog2(DEPTH);

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     cnt_q;
    logic            do_push;
    logic            do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];

    // NOTE: storage has no reset; the occupancy count alone decides which slots are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
            else if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/result_tx_framer.sv
// Buffers result entries and serialises them as SOF / {index, data} ... / EOF /
// count / checksum frames to a byte UART, one byte per idle transmitter.
module result_tx_framer
    import coproc_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] SOF_BYTE   = DEFAULT_SOF_BYTE,
    parameter logic [7:0] EOF_BYTE   = DEFAULT_EOF_BYTE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ent_valid,
    output logic        ent_ready,
    input  logic [7:0]  ent_index,
    input  logic [15:0] ent_data,
    input  logic        ent_last,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        frame_done
);

    result_entry_t in_ent;
    result_entry_t head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;

    frame_state_t  state_q, state_d;
    frame_state_t  resume_q, resume_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_start_q, tx_start_d;
    logic          frame_done_q, frame_done_d;
    logic [7:0]    count_q, count_d;
    logic [7:0]    sum_q, sum_d;

    logic          want;
    logic          add_sum;
    logic [7:0]    byte_v;
    frame_state_t  next_v;

    assign in_ent     = '{index: ent_index, data: ent_data, last: ent_last};
    assign ent_ready  = !fifo_full;
    assign tx_data    = tx_data_q;
    assign tx_start   = tx_start_q;
    assign frame_done = frame_done_q;

    result_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (result_entry_t)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (ent_valid && ent_ready),
        .din_i   (in_ent),
        .pop_i   (fifo_pop),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        resume_d     = resume_q;
        tx_data_d    = tx_data_q;
        tx_start_d   = 1'b0;
        frame_done_d = 1'b0;
        count_d      = count_q;
        sum_d        = sum_q;
        fifo_pop     = 1'b0;
        want         = 1'b0;
        add_sum      = 1'b0;
        byte_v       = 8'h00;
        next_v       = ST_IDLE;

        case (state_q)
            ST_IDLE:  if (!fifo_empty) state_d = ST_SOF;
            ST_SOF:   begin want = 1'b1;        byte_v = SOF_BYTE;          next_v = ST_IDX; end
            ST_IDX:   begin want = !fifo_empty; byte_v = head.index;        next_v = ST_DHI; add_sum = 1'b1; end
            ST_DHI:   begin want = 1'b1;        byte_v = head.data[15:8];   next_v = ST_DLO; add_sum = 1'b1; end
            ST_DLO:   begin
                want    = 1'b1;
                byte_v  = head.data[7:0];
                next_v  = head.last ? ST_EOF : ST_IDX;
                add_sum = 1'b1;
            end
            ST_EOF:   begin want = 1'b1;        byte_v = EOF_BYTE;          next_v = ST_CNT; end
            ST_CNT:   begin want = 1'b1;        byte_v = count_q;           next_v = ST_CHK; add_sum = 1'b1; end
            ST_CHK:   begin want = 1'b1;        byte_v = ~sum_q + 8'd1;     next_v = ST_IDLE; end
            ST_GUARD: begin
                state_d = resume_q;
                if (resume_q == ST_IDLE) begin
                    frame_done_d = 1'b1;
                    count_d      = 8'h00;
                    sum_d        = 8'h00;
                end
            end
            default:  state_d = ST_IDLE;
        endcase

        // The guard cycle covers the gap before the transmitter raises busy.
        if (want && !tx_busy) begin
            tx_start_d = 1'b1;
            tx_data_d  = byte_v;
            state_d    = ST_GUARD;
            resume_d   = next_v;
            if (add_sum) sum_d = sum_q + byte_v;
            if (state_q == ST_DLO) begin
                fifo_pop = 1'b1;
                count_d  = count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            resume_q     <= ST_IDLE;
            tx_data_q    <= 8'h00;
            tx_start_q   <= 1'b0;
            frame_done_q <= 1'b0;
            count_q      <= 8'h00;
            sum_q        <= 8'h00;
        end else begin
            state_q      <= state_d;
            resume_q     <= resume_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            frame_done_q <= frame_done_d;
            count_q      <= count_d;
            sum_q        <= sum_d;
        end
    end

endmodule

// File: tb/tb_result_tx_framer.sv
// Directed bench for result_tx_framer: table of hand-computed frames plus
// sequences for back-pressure, mid-frame reset, back-to-back and 257-entry frames.
module tb_result_tx_framer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ent_valid = 1'b0;
    logic        ent_ready;
    logic [7:0]  ent_index = 8'h00;
    logic [15:0] ent_data = 16'h0000;
    logic        ent_last = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        frame_done;

    always #5 clk = ~clk;

    result_tx_framer dut (
        .clk        (clk),
        .reset      (reset),
        .ent_valid  (ent_valid),
        .ent_ready  (ent_ready),
        .ent_index  (ent_index),
        .ent_data   (ent_data),
        .ent_last   (ent_last),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .frame_done (frame_done)
    );

    typedef struct packed {
        logic [7:0]  idx;
        logic [15:0] dat;
        logic        last;
    } ent_t;

    typedef struct packed {
        logic [7:0]   n_ent;
        logic [95:0]  ents;     // entry k at [24*(n_ent-1-k) +: 24] as {idx, dat}
        logic [7:0]   busy;
        logic [7:0]   n_bytes;
        logic [127:0] bytes;    // byte k at [8*(n_bytes-1-k) +: 8]
    } vec_t;

    vec_t       vecs [5];
    ent_t       ent_q [$];
    logic [7:0] exp_q [$];
    logic [7:0] cap [$];
    int         n_vec = 0;
    int         n_miss = 0;
    int         fd_cnt = 0;
    int         viol = 0;
    int         busy_len = 0;
    bit         busy_stuck = 1'b0;
    int         busy_cnt = 0;

    // UART model: busy for busy_len cycles after each start strobe.
    assign tx_busy = busy_stuck || (busy_cnt > 0);

    always @(posedge clk or posedge reset) begin
        if (reset)               busy_cnt <= 0;
        else if (tx_start)       busy_cnt <= busy_len;
        else if (busy_cnt > 0)   busy_cnt <= busy_cnt - 1;
    end

    always @(negedge clk) begin
        if (tx_start) begin
            cap.push_back(tx_data);
            if (tx_busy) viol++;
        end
        if (frame_done) fd_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cap.delete();
        fd_cnt = 0;
        viol = 0;
    endtask

    task automatic push_ent(input ent_t e);
        bit ok;
        @(negedge clk);
        ent_valid = 1'b1;
        ent_index = e.idx;
        ent_data  = e.dat;
        ent_last  = e.last;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            if (ent_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        ent_valid = 1'b0;
        check("push_accept", 32'(ok), 32'd1);
    endtask

    // Reference frame builder working from the entry list.
    function automatic void build_exp();
        bit         new_frame = 1'b1;
        logic [7:0] cnt = 8'h00;
        logic [7:0] sum = 8'h00;
        exp_q.delete();
        foreach (ent_q[i]) begin
            if (new_frame) exp_q.push_back(8'hA5);
            exp_q.push_back(ent_q[i].idx);
            exp_q.push_back(ent_q[i].dat[15:8]);
            exp_q.push_back(ent_q[i].dat[7:0]);
            sum = sum + ent_q[i].idx + ent_q[i].dat[15:8] + ent_q[i].dat[7:0];
            cnt = cnt + 8'd1;
            new_frame = ent_q[i].last;
            if (ent_q[i].last) begin
                sum = sum + cnt;
                exp_q.push_back(8'h5A);
                exp_q.push_back(cnt);
                exp_q.push_back(8'h00 - sum);
                cnt = 8'h00;
                sum = 8'h00;
            end
        end
    endfunction

    task automatic run_frames(input int n_frames, input int bound, input string tag);
        cap.delete();
        fd_cnt = 0;
        viol = 0;
        foreach (ent_q[i]) push_ent(ent_q[i]);
        for (int i = 0; i < bound && fd_cnt < n_frames; i++) @(negedge clk);
        repeat (6) @(negedge clk);
        check({tag, " frame_done"}, 32'(fd_cnt), 32'(n_frames));
        check({tag, " nbytes"}, 32'(cap.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < cap.size(); k++)
            check($sformatf("%s byte%0d", tag, k), cap[k], exp_q[k]);
        check({tag, " busy_viol"}, 32'(viol), 32'd0);
        if (exp_q.size() > 0)
            check({tag, " tx_data_hold"}, tx_data, exp_q[exp_q.size()-1]);
    endtask

    initial begin
        vecs[0] = '{n_ent: 8'd1, ents: 96'h033C00, busy: 8'd0, n_bytes: 8'd7,
                    bytes: 128'hA5_033C00_5A01C0};
        // checksum = -(01+00+01+02+00+02 + count 02) = -08 = F8
        vecs[1] = '{n_ent: 8'd2, ents: 96'h010001_020002, busy: 8'd0, n_bytes: 8'd10,
                    bytes: 128'hA5_010001_020002_5A02F8};
        vecs[2] = '{n_ent: 8'd1, ents: 96'h033C00, busy: 8'd10, n_bytes: 8'd7,
                    bytes: 128'hA5_033C00_5A01C0};
        vecs[3] = '{n_ent: 8'd1, ents: 96'hFFFFFF, busy: 8'd2, n_bytes: 8'd7,
                    bytes: 128'hA5_FFFFFF_5A0102};
        vecs[4] = '{n_ent: 8'd3, ents: 96'h101234_20ABCD_300000, busy: 8'd0, n_bytes: 8'd13,
                    bytes: 128'hA5_101234_20ABCD_300000_5A03DF};

        // Reset state
        #1;
        check("rst tx_start", 32'(tx_start), 32'd0);
        check("rst tx_data", 32'(tx_data), 32'd0);
        check("rst frame_done", 32'(frame_done), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst ent_ready", 32'(ent_ready), 32'd1);

        // Table of hand-computed frames
        for (int v = 0; v < 5; v++) begin
            int n;
            int nb;
            logic [23:0] e;
            n  = int'(vecs[v].n_ent);
            nb = int'(vecs[v].n_bytes);
            ent_q.delete();
            exp_q.delete();
            for (int k = 0; k < n; k++) begin
                e = vecs[v].ents[24*(n-1-k) +: 24];
                ent_q.push_back('{idx: e[23:16], dat: e[15:0], last: (k == n-1)});
            end
            for (int k = 0; k < nb; k++) exp_q.push_back(vecs[v].bytes[8*(nb-1-k) +: 8]);
            busy_len = int'(vecs[v].busy);
            run_frames(1, 2000, $sformatf("vec%0d", v));
        end

        // Back-pressure: transmitter stuck busy, FIFO fills after four entries
        do_reset();
        busy_len = 0;
        busy_stuck = 1'b1;
        ent_q.delete();
        for (int i = 0; i < 6; i++)
            ent_q.push_back('{idx: 8'(i + 1), dat: 16'h1000 + 16'(i), last: (i == 5)});
        for (int i = 0; i < 4; i++) push_ent(ent_q[i]);
        @(negedge clk);
        check("bp ready_after4", 32'(ent_ready), 32'd0);
        ent_valid = 1'b1;
        ent_index = ent_q[4].idx;
        ent_data  = ent_q[4].dat;
        ent_last  = ent_q[4].last;
        repeat (8) @(negedge clk);
        check("bp ready_held", 32'(ent_ready), 32'd0);
        check("bp no_start", 32'(cap.size()), 32'd0);
        busy_stuck = 1'b0;
        push_ent(ent_q[4]);
        push_ent(ent_q[5]);
        build_exp();
        for (int i = 0; i < 3000 && fd_cnt < 1; i++) @(negedge clk);
        repeat (6) @(negedge clk);
        check("bp frame_done", 32'(fd_cnt), 32'd1);
        check("bp nbytes", 32'(cap.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < cap.size(); k++)
            check($sformatf("bp byte%0d", k), cap[k], exp_q[k]);
        check("bp busy_viol", 32'(viol), 32'd0);

        // Reset right after the DHI byte aborts the frame and drops the queued entry
        do_reset();
        busy_len = 0;
        push_ent('{idx: 8'h01, dat: 16'h1234, last: 1'b0});
        push_ent('{idx: 8'h02, dat: 16'h5678, last: 1'b1});
        for (int i = 0; i < 200 && cap.size() < 3; i++) begin
            @(negedge clk);
            #1;
        end
        check("mid nbytes_at_dhi", 32'(cap.size()), 32'd3);
        if (cap.size() >= 3) check("mid dhi_byte", cap[2], 8'h12);
        reset = 1'b1;
        #1;
        check("mid tx_start", 32'(tx_start), 32'd0);
        check("mid tx_data", 32'(tx_data), 32'd0);
        check("mid frame_done", 32'(frame_done), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid ent_ready", 32'(ent_ready), 32'd1);
        cap.delete();
        fd_cnt = 0;
        repeat (12) @(negedge clk);
        check("mid no_resume", 32'(cap.size()), 32'd0);
        check("mid no_done", 32'(fd_cnt), 32'd0);
        ent_q.delete();
        ent_q.push_back('{idx: 8'h03, dat: 16'h3C00, last: 1'b1});
        build_exp();
        run_frames(1, 2000, "post_rst");

        // last=1 followed by another entry starts a second frame
        ent_q.delete();
        ent_q.push_back('{idx: 8'h03, dat: 16'h3C00, last: 1'b1});
        ent_q.push_back('{idx: 8'h7E, dat: 16'hC0DE, last: 1'b1});
        build_exp();
        run_frames(2, 2000, "b2b");

        // 257 zero entries: count wraps to 01, checksum FF
        ent_q.delete();
        for (int i = 0; i < 257; i++)
            ent_q.push_back('{idx: 8'h00, dat: 16'h0000, last: (i == 256)});
        build_exp();
        run_frames(1, 5000, "e257");
        if (cap.size() >= 2) begin
            check("e257 count", cap[cap.size()-2], 8'h01);
            check("e257 checksum", cap[cap.size()-1], 8'hFF);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no end, expected summary");
        $fatal(1, "timeout");
    end

endmodule
